// File: rtl/master_slave_arbiter.sv
// Round-robin poller over NUM_CH slave channels with optional
// per-channel saturating accumulation; 3-phase poll/process/publish.
module master_slave_arbiter #(
  parameter int DATA_W   = 32,
  parameter int NUM_CH   = 4,
  parameter int ACC_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] s_in,
  input  logic [NUM_CH-1:0]        s_in_sync,
  input  logic                     acc_clr,
  output logic [DATA_W-1:0]        s_out,
  output logic [$clog2(NUM_CH)-1:0] s_out_ch,
  output logic                     s_out_valid,
  output logic [1:0]               phase
);

  localparam int CW = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    SEC_A = 2'd0,
    SEC_B = 2'd1,
    SEC_C = 2'd2
  } state_t;

  state_t state;

  logic [DATA_W-1:0] val;
  logic [CW-1:0]     ch;
  logic [CW-1:0]     ptr;
  logic [DATA_W-1:0] acc [NUM_CH];
  logic [DATA_W-1:0] ch_data [NUM_CH];

  logic              hit;
  logic [CW-1:0]     gidx;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] result;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_slice
    assign ch_data[c] = s_in[c*DATA_W +: DATA_W];
  end

  assign phase = state;

  // Grant search: first flagged channel starting at ptr, wrapping
  always_comb begin
    int j;
    hit  = 1'b0;
    gidx = '0;
    j    = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!hit && s_in_sync[j]) begin
        hit  = 1'b1;
        gidx = CW'(j);
      end
    end
  end

  // Result: pass-through, or saturating sum (from zero on clear)
  always_comb begin
    sum    = {acc[ch][DATA_W-1], acc[ch]} + {val[DATA_W-1], val};
    result = val;
    if (ACC_MODE == 1 && !acc_clr) begin
      if (sum[DATA_W] != sum[DATA_W-1])
        result = sum[DATA_W] ? SAT_MIN : SAT_MAX;
      else
        result = sum[DATA_W-1:0];
    end
  end

  // Phase machine, transaction registers and published outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= SEC_A;
      val         <= '0;
      ch          <= '0;
      ptr         <= '0;
      s_out       <= '0;
      s_out_ch    <= '0;
      s_out_valid <= 1'b0;
    end else begin
      unique case (state)
        SEC_A: begin
          if (hit) begin
            val   <= ch_data[gidx];
            ch    <= gidx;
            state <= SEC_B;
          end
        end
        SEC_B: begin
          s_out       <= result;
          s_out_ch    <= ch;
          s_out_valid <= 1'b1;
          state       <= SEC_C;
        end
        SEC_C: begin
          s_out_valid <= 1'b0;
          ptr         <= (int'(ch) == NUM_CH-1) ? '0 : ch + 1'b1;
          state       <= SEC_A;
        end
        default: state <= SEC_A;
      endcase
    end
  end

  // Per-channel accumulators; clear wins except for the served channel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
    end else if (ACC_MODE == 1) begin
      if (acc_clr) begin
        for (int c = 0; c < NUM_CH; c++)
          acc[c] <= (state == SEC_B && c == int'(ch)) ? val : '0;
      end else if (state == SEC_B) begin
        acc[ch] <= result;
      end
    end
  end

endmodule

// File: tb/tb_master_slave_arbiter.sv
// Directed bench: pass-through instance (32b) and accumulate instance (8b).
// Expected values are hand-computed per scenario.
module tb_master_slave_arbiter;

  logic clk;
  logic rst;

  logic [127:0]       s_in0;
  logic [3:0]         sync0;
  logic               acc_clr0;
  logic signed [31:0] s_out0;
  logic [1:0]         s_out_ch0;
  logic               s_out_valid0;
  logic [1:0]         phase0;

  logic [31:0]       s_in1;
  logic [3:0]        sync1;
  logic              acc_clr1;
  logic signed [7:0] s_out1;
  logic [1:0]        s_out_ch1;
  logic              s_out_valid1;
  logic [1:0]        phase1;

  int cnt;
  int fails;

  master_slave_arbiter #(.DATA_W(32), .NUM_CH(4), .ACC_MODE(0)) u_pass (
    .clk(clk), .rst(rst), .s_in(s_in0), .s_in_sync(sync0),
    .acc_clr(acc_clr0), .s_out(s_out0), .s_out_ch(s_out_ch0),
    .s_out_valid(s_out_valid0), .phase(phase0)
  );

  master_slave_arbiter #(.DATA_W(8), .NUM_CH(4), .ACC_MODE(1)) u_acc (
    .clk(clk), .rst(rst), .s_in(s_in1), .s_in_sync(sync1),
    .acc_clr(acc_clr1), .s_out(s_out1), .s_out_ch(s_out_ch1),
    .s_out_valid(s_out_valid1), .phase(phase1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run0(input logic [3:0] flags,
                      output logic signed [31:0] o,
                      output logic [1:0] oc, output logic ov);
    sync0 = flags;
    @(posedge clk); #1;
    sync0 = 4'b0;
    @(posedge clk); #1;
    o = s_out0; oc = s_out_ch0; ov = s_out_valid0;
    @(posedge clk); #1;
  endtask

  task automatic run1(input int c, input logic signed [7:0] d,
                      input bit clr,
                      output logic signed [7:0] o,
                      output logic [1:0] oc, output logic ov);
    s_in1[c*8 +: 8] = d;
    sync1 = 4'b0;
    sync1[c] = 1'b1;
    @(posedge clk); #1;
    sync1 = 4'b0;
    acc_clr1 = clr;
    @(posedge clk); #1;
    acc_clr1 = 1'b0;
    o = s_out1; oc = s_out_ch1; ov = s_out_valid1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    s_in0 = '0; sync0 = '0; acc_clr0 = 1'b0;
    s_in1 = '0; sync1 = '0; acc_clr1 = 1'b0;
    #12;
    cnt++;
    if ({phase0, s_out0, s_out_ch0, s_out_valid0} !== 37'd0) begin
      fails++;
      $display("FAIL reset_pass got ph=%0d out=%0d ch=%0d v=%0d exp all 0",
               phase0, s_out0, s_out_ch0, s_out_valid0);
    end
    cnt++;
    if ({phase1, s_out1, s_out_ch1, s_out_valid1} !== 13'd0) begin
      fails++;
      $display("FAIL reset_acc got ph=%0d out=%0d ch=%0d v=%0d exp all 0",
               phase1, s_out1, s_out_ch1, s_out_valid1);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    s_in0[2*32 +: 32] = -32'sd7;
    sync0 = 4'b0100;
    @(posedge clk); #1;
    sync0 = 4'b0;
    cnt++;
    if (phase0 !== 2'd1) begin
      fails++;
      $display("FAIL single_grant phase got %0d exp 1", phase0);
    end
    @(posedge clk); #1;
    cnt++;
    if (s_out0 !== -32'sd7 || s_out_ch0 !== 2'd2 || s_out_valid0 !== 1'b1) begin
      fails++;
      $display("FAIL single_out got out=%0d ch=%0d v=%0d exp -7 2 1",
               s_out0, s_out_ch0, s_out_valid0);
    end
    @(posedge clk); #1;
    cnt++;
    if (s_out_valid0 !== 1'b0 || phase0 !== 2'd0 || s_out0 !== -32'sd7) begin
      fails++;
      $display("FAIL single_fall got v=%0d ph=%0d out=%0d exp 0 0 -7",
               s_out_valid0, phase0, s_out0);
    end
  endtask

  task automatic test_no_clr_passthrough();
    logic signed [31:0] o;
    logic [1:0] oc;
    logic ov;
    acc_clr0 = 1'b1;
    s_in0[0 +: 32] = 32'sd42;
    run0(4'b0001, o, oc, ov);
    cnt++;
    if (o !== 32'sd42 || oc !== 2'd0) begin
      fails++;
      $display("FAIL pass_clr1 got %0d ch %0d exp 42 ch 0", o, oc);
    end
    s_in0[0 +: 32] = 32'sd8;
    run0(4'b0001, o, oc, ov);
    cnt++;
    if (o !== 32'sd8) begin
      fails++;
      $display("FAIL pass_clr2 got %0d exp 8", o);
    end
    acc_clr0 = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ch;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) s_in0[c*32 +: 32] = c * 1000 - 3;
    sync0 = 4'b1111;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_ch = 2'(i % 4);
      @(posedge clk);
      @(posedge clk); #1;
      cnt++;
      if (s_out_valid0 !== 1'b1 || s_out_ch0 !== exp_ch ||
          s_out0 !== 32'(int'(exp_ch) * 1000 - 3)) begin
        fails++;
        $display("FAIL rr_%0d got v=%0d ch=%0d out=%0d exp 1 %0d %0d",
                 i, s_out_valid0, s_out_ch0, s_out0, exp_ch,
                 int'(exp_ch) * 1000 - 3);
      end
      @(posedge clk); #1;
      cnt++;
      if (s_out_valid0 !== 1'b0 || phase0 !== 2'd0) begin
        fails++;
        $display("FAIL rr_gap_%0d got v=%0d ph=%0d exp 0 0",
                 i, s_out_valid0, phase0);
      end
    end
    sync0 = 4'b0;
  endtask

  task automatic test_fairness();
    logic signed [31:0] o;
    logic [1:0] oc;
    logic ov;
    logic [3:0] flg [4];
    logic [1:0] exp_ch [4];
    flg[0] = 4'b0010; exp_ch[0] = 2'd1;
    flg[1] = 4'b1011; exp_ch[1] = 2'd3;
    flg[2] = 4'b1011; exp_ch[2] = 2'd0;
    flg[3] = 4'b1011; exp_ch[3] = 2'd1;
    for (int i = 0; i < 4; i++) begin
      run0(flg[i], o, oc, ov);
      cnt++;
      if (oc !== exp_ch[i] || ov !== 1'b1) begin
        fails++;
        $display("FAIL fair_%0d got ch=%0d v=%0d exp ch=%0d v=1",
                 i, oc, ov, exp_ch[i]);
      end
    end
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      cnt++;
      if (phase0 !== 2'd0 || s_out_valid0 !== 1'b0 || s_out0 !== 32'sd997) begin
        fails++;
        $display("FAIL idle_%0d got ph=%0d v=%0d out=%0d exp 0 0 997",
                 i, phase0, s_out_valid0, s_out0);
      end
    end
  endtask

  task automatic test_accumulate();
    logic signed [7:0] o;
    logic [1:0] oc;
    logic ov;
    run1(2, 8'sd10, 1'b0, o, oc, ov);
    cnt++;
    if (o !== 8'sd10 || oc !== 2'd2 || ov !== 1'b1) begin
      fails++;
      $display("FAIL acc_first got %0d ch %0d v %0d exp 10 2 1", o, oc, ov);
    end
    run1(2, 8'sd20, 1'b0, o, oc, ov);
    cnt++;
    if (o !== 8'sd30) begin
      fails++;
      $display("FAIL acc_sum got %0d exp 30", o);
    end
  endtask

  task automatic test_saturate();
    logic signed [7:0] o;
    logic [1:0] oc;
    logic ov;
    logic signed [7:0] din [4];
    logic signed [7:0] exp_o [4];
    din[0] = 8'sd100;  exp_o[0] = 8'sd100;
    din[1] = 8'sd100;  exp_o[1] = 8'sd127;
    din[2] = -8'sd128; exp_o[2] = -8'sd128;
    din[3] = -8'sd128; exp_o[3] = -8'sd128;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        acc_clr1 = 1'b1;
        @(posedge clk); #1;
        acc_clr1 = 1'b0;
      end
      run1(1, din[i], 1'b0, o, oc, ov);
      cnt++;
      if (o !== exp_o[i] || oc !== 2'd1) begin
        fails++;
        $display("FAIL sat_%0d got %0d ch %0d exp %0d ch 1",
                 i, o, oc, exp_o[i]);
      end
    end
  endtask

  task automatic test_clr_at_process();
    logic signed [7:0] o;
    logic [1:0] oc;
    logic ov;
    int c_t [6];
    logic signed [7:0] din [6];
    bit clr [6];
    logic signed [7:0] exp_o [6];
    c_t[0] = 2; din[0] = 8'sd7;  clr[0] = 0; exp_o[0] = 8'sd7;
    c_t[1] = 0; din[1] = 8'sd50; clr[1] = 0; exp_o[1] = 8'sd50;
    c_t[2] = 0; din[2] = 8'sd5;  clr[2] = 1; exp_o[2] = 8'sd5;
    c_t[3] = 0; din[3] = 8'sd0;  clr[3] = 0; exp_o[3] = 8'sd5;
    c_t[4] = 1; din[4] = 8'sd0;  clr[4] = 0; exp_o[4] = 8'sd0;
    c_t[5] = 2; din[5] = 8'sd0;  clr[5] = 0; exp_o[5] = 8'sd0;
    for (int i = 0; i < 6; i++) begin
      run1(c_t[i], din[i], clr[i], o, oc, ov);
      cnt++;
      if (o !== exp_o[i] || oc !== 2'(c_t[i])) begin
        fails++;
        $display("FAIL clrb_%0d got %0d ch %0d exp %0d ch %0d",
                 i, o, oc, exp_o[i], c_t[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    s_in0[1*32 +: 32] = 32'sd99;
    sync0 = 4'b0010;
    @(posedge clk); #1;
    sync0 = 4'b0;
    cnt++;
    if (phase0 !== 2'd1) begin
      fails++;
      $display("FAIL rmid_phase got %0d exp 1", phase0);
    end
    #2;
    rst = 1'b0;
    #1;
    cnt++;
    if ({phase0, s_out0, s_out_ch0, s_out_valid0} !== 37'd0) begin
      fails++;
      $display("FAIL rmid_async got ph=%0d out=%0d ch=%0d v=%0d exp all 0",
               phase0, s_out0, s_out_ch0, s_out_valid0);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      cnt++;
      if (s_out_valid0 !== 1'b0 || phase0 !== 2'd0) begin
        fails++;
        $display("FAIL rmid_after_%0d got v=%0d ph=%0d exp 0 0",
                 i, s_out_valid0, phase0);
      end
    end
  endtask

  initial begin
    cnt = 0;
    fails = 0;
    test_reset();
    test_single();
    test_no_clr_passthrough();
    test_round_robin();
    test_fairness();
    test_idle();
    test_accumulate();
    test_saturate();
    test_clr_at_process();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             cnt, fails);
    $finish;
  end

endmodule
